// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result bus for adder_pipe.
//   Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high. A producer holding valid keeps its payload stable until
//   that edge; ready may depend combinationally on the other side's ready.
//   master = operand producer + result consumer, slave = the adder.
interface adder_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: two-stage pipelined N-bit adder, Sum = A + B + Cin.
//   Stage 1 ripples the low half (bits H-1:0) and registers the carry out of
//   bit H-1 together with the operand high halves; stage 2 ripples the high
//   half from that carry and registers Sum/Cout/Ovf, which drive the outputs
//   directly. Each bit position is a full-adder cell.
//   N must be even and >= 2; H = N/2.
//   Optional build macro ADDER_PIPE_SAT_EN: stage 2 clamps Sum to the signed
//   max/min when the add overflows; Cout/Ovf still describe the raw add.
//   Without the macro Sum is the raw modulo-2^N result.
module adder_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  adder_pipe_if.slave  bus
);

  localparam int H = N / 2;

  // Full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
    return {co, s};
  endfunction

  // Stage 1 registers
  logic         s1_valid;
  logic [H-1:0] s1_lo;
  logic         s1_c;
  logic [H-1:0] s1_ahi;
  logic [H-1:0] s1_bhi;

  // Stage 2 registers (these are the outputs)
  logic         s2_valid;
  logic [N-1:0] s2_sum;
  logic         s2_cout;
  logic         s2_ovf;

  // Advance controls: a stage may load when it is empty or its content
  // leaves this cycle. Stage 1 can drain into a stage 2 that is draining,
  // so a full pipe with out_ready=1 still accepts a new operand.
  logic s1_adv;
  logic s2_adv;

  assign s2_adv = ~s2_valid | bus.out_ready;
  assign s1_adv = ~s1_valid | s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.Sum       = s2_sum;
  assign bus.Cout      = s2_cout;
  assign bus.Ovf       = s2_ovf;

  // Low-half carry chain from Cin over A/B bits H-1:0.
  logic [H:0]   lo_c;
  logic [H-1:0] lo_sum;

  // Ripple the low half through H full-adder cells.
  always_comb begin
    lo_c    = '0;
    lo_sum  = '0;
    lo_c[0] = bus.Cin;
    for (int i = 0; i < H; i++) begin
      {lo_c[i+1], lo_sum[i]} = full_adder(bus.A[i], bus.B[i], lo_c[i]);
    end
  end

  // High-half carry chain, fed by the carry registered in stage 1.
  logic [H:0]   hi_c;
  logic [H-1:0] hi_sum;

  // Ripple the high half through H full-adder cells.
  always_comb begin
    hi_c    = '0;
    hi_sum  = '0;
    hi_c[0] = s1_c;
    for (int i = 0; i < H; i++) begin
      {hi_c[i+1], hi_sum[i]} = full_adder(s1_ahi[i], s1_bhi[i], hi_c[i]);
    end
  end

  logic [N-1:0] raw_sum;
  logic         cout_next;
  logic         ovf_next;
  logic [N-1:0] sum_next;

  assign raw_sum   = {hi_sum, s1_lo};
  assign cout_next = hi_c[H];
  // Signed overflow: operands share a sign and the result's sign differs.
  assign ovf_next  = (s1_ahi[H-1] == s1_bhi[H-1]) && (hi_sum[H-1] != s1_ahi[H-1]);

`ifdef ADDER_PIPE_SAT_EN
  // Overflow with a non-negative A can only go past the max positive value,
  // with a negative A only past the min negative value.
  logic [N-1:0] sat_val;
  assign sat_val  = s1_ahi[H-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign sum_next = ovf_next ? sat_val : raw_sum;
`else
  assign sum_next = raw_sum;
`endif

  // Stage 1: capture the low-half result and operand high halves on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      s1_lo    <= lo_sum;
      s1_c     <= lo_c[H];
      s1_ahi   <= bus.A[N-1:H];
      s1_bhi   <= bus.B[N-1:H];
    end
  end

  // Stage 2: finish the high half and register the visible result on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_sum   <= sum_next;
      s2_cout  <= cout_next;
      s2_ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: self-checking bench for adder_pipe (N=8).
//   Reference model: a two-entry FIFO of expected results computed with
//   plain integer arithmetic; each entry becomes visible two cycles after
//   its operands were accepted. Define ADDER_PIPE_SAT_EN for both bench and
//   RTL to cover the saturating build.
module tb_adder_pipe;

  localparam int N = 8;
  localparam int W = N + 2;

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [7:0] EXP_7F_01 = 8'h7F;
  localparam logic [7:0] EXP_80_FF = 8'h80;
`else
  localparam logic [7:0] EXP_7F_01 = 8'h80;
  localparam logic [7:0] EXP_80_FF = 8'h7F;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_pipe_if #(.N(N)) bus ();

  adder_pipe #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard: {sum, cout, ovf} per accepted op, plus the cycle it may appear.
  logic [W-1:0] exp_q[$];
  int unsigned  rdy_q[$];
  logic [N-1:0] out_log[$];
  int unsigned  step_no = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic         last_acc;
  logic         last_ir;
  logic         last_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: whole-number add, then wrap / flag / clamp.
  function automatic logic [W-1:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin);
    longint       u;
    longint       s;
    longint       max_s;
    longint       min_s;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    max_s = (longint'(1) <<< (N - 1)) - 1;
    min_s = -(longint'(1) <<< (N - 1));
    u     = longint'(a) + longint'(b) + longint'(cin);
    s     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    sum   = u[N-1:0];
    cout  = u[N];
    ovf   = (s > max_s) || (s < min_s);
`ifdef ADDER_PIPE_SAT_EN
    if (ovf) sum = (s < 0) ? max_s[N-1:0] + 1'b1 : max_s[N-1:0];
`endif
    return {sum, cout, ovf};
  endfunction

  // Driver + monitor for one clock cycle.
  task automatic step(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic ordy);
    logic         exp_rdy;
    logic         exp_ov;
    logic         emit;
    logic [W-1:0] front;
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.Cin       = cin;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() < 2) || ordy;
    exp_ov  = (exp_q.size() > 0) && (step_no >= rdy_q[0]);
    last_ir = bus.in_ready;
    last_ov = bus.out_valid;
    check("in_ready", bus.in_ready, exp_rdy);
    check("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      front = exp_q[0];
      check("sum", bus.Sum, front[W-1:2]);
      check("cout", bus.Cout, front[1]);
      check("ovf", bus.Ovf, front[0]);
      if (ordy) out_log.push_back(bus.Sum);
    end
    emit     = exp_ov && ordy;
    last_acc = iv && exp_rdy;
    @(posedge clk);
    if (emit) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    if (last_acc) begin
      exp_q.push_back(ref_add(a, b, cin));
      rdy_q.push_back(step_no + 2);
    end
    step_no++;
  endtask

  // Hold reset for some cycles with operands offered, then check the cleared state.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = N'($urandom);
    bus.B         = N'($urandom);
    bus.Cin       = 1'b1;
    bus.out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    exp_q.delete();
    rdy_q.delete();
    step_no += cycles;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.Sum, 0);
    check("rst_cout", bus.Cout, 0);
    check("rst_ovf", bus.Ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
  endtask

  // One op into an empty pipe: invisible after one edge, visible after two.
  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic [N-1:0] esum, input logic ecout,
                          input logic eovf);
    step(1'b1, a, b, cin, 1'b1);
    #1;
    check({tag, "_lat1"}, bus.out_valid, 0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check({tag, "_lat2"}, bus.out_valid, 1);
    check({tag, "_sum"}, bus.Sum, esum);
    check({tag, "_cout"}, bus.Cout, ecout);
    check({tag, "_ovf"}, bus.Ovf, eovf);
    step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int idx;
    int t;
    int n_acc;
    logic ir_t3;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.out_ready = 1'b0;
    do_reset(2);

    // Directed vectors
    directed("mid_carry", 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
    directed("wrap",      8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    directed("pos_ovf",   8'h7F, 8'h01, 1'b0, EXP_7F_01, 1'b0, 1'b1);
    directed("neg_ovf",   8'h80, 8'hFF, 1'b0, EXP_80_FF, 1'b1, 1'b1);

    // Backpressure: 1+1..4+4 back to back, out_ready low for 3 cycles from first out_valid
    out_log.delete();
    idx   = 0;
    t     = 0;
    ir_t3 = 1'b1;
    while ((idx < 4 || exp_q.size() > 0) && t < 40) begin
      t++;
      if (idx < 4) step(1'b1, N'(idx + 1), N'(idx + 1), 1'b0, !(t >= 3 && t <= 5));
      else         step(1'b0, '0, '0, 1'b0, !(t >= 3 && t <= 5));
      if (t == 3) ir_t3 = last_ir;
      if (last_acc) idx++;
    end
    check("bp_done", (idx == 4 && exp_q.size() == 0), 1);
    check("bp_in_ready_drop", ir_t3, 0);
    check("bp_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("bp_order", out_log[i], 2 * (i + 1));
    end

    // Continuous stream of 16 ops: no bubbles after the 2-cycle fill
    n_acc = 0;
    for (int k = 1; k <= 18; k++) begin
      if (k <= 16) step(1'b1, N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      else         step(1'b0, '0, '0, 1'b0, 1'b1);
      if (last_acc) n_acc++;
      if (k >= 3) check("stream_no_bubble", last_ov, 1);
    end
    check("stream_accepts", n_acc, 16);

    // Reset with two ops in flight, then a normal op
    step(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 8'h44, 1'b0, 1'b1);
    do_reset(1);
    directed("post_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Random soak with random backpressure
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), N'($urandom), N'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    t = 0;
    while (exp_q.size() > 0 && t < 10) begin
      t++;
      step(1'b0, '0, '0, 1'b0, 1'b1);
    end
    check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
